// File: rtl/shift_receiver_5bit_pkg.sv
// Constants shared by the 5-bit serial link endpoints: FSM encoding and default width.
// Combinational only; no latency and no backpressure.
package shift_receiver_5bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/shift_receiver_5bit_sipo_shift_core.sv
// Right-shift register, LSB arrives first and drifts toward bit 0 as newer bits enter at the MSB.
// Updates one edge after load_first/shift_en; never stalls and has no backpressure.
module sipo_shift_core
  import shift_receiver_5bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_first,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] shreg
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // A new frame clears the older bits so a resynced partial frame leaves no trace.
  always_comb begin
    shreg_d = shreg_q;
    if (load_first) begin
      shreg_d = {din, {(WIDTH-1){1'b0}}};
    end else if (shift_en) begin
      shreg_d = {din, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg = shreg_q;

endmodule

// File: rtl/shift_receiver_5bit.sv
// Serial-in/parallel-out receiver: word valid WIDTH-1 edges after the frameStart edge.
// No backpressure on the serial side; an unacked word is overwritten and flagged by sticky overrun.
module shift_receiver_5bit
  import shift_receiver_5bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clockpulse,
  input  logic             notclear,
  input  logic             serialInput,
  input  logic             frameStart,
  input  logic             readAck,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] notout,
  output logic             dataValid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shreg;
  logic             in_shift;
  logic             frame_done;
  logic             shift_en;

  assign in_shift   = (state_q == ST_SHIFT);
  assign frame_done = in_shift && !frameStart && (cnt_q == LAST_CNT);
  assign shift_en   = in_shift && !frameStart && (cnt_q != LAST_CNT);

  sipo_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clockpulse),
    .rst_n      (notclear),
    .load_first (frameStart),
    .shift_en   (shift_en),
    .din        (serialInput),
    .shreg      (shreg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dv_d    = dv_q;
    ovr_d   = ovr_q;

    if (frameStart) begin
      state_d = ST_SHIFT;
      cnt_d   = CW'(1);
    end else if (frame_done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_shift) begin
      cnt_d   = cnt_q + CW'(1);
    end

    // Completion wins over ack; a completion without ack on a held word is an overrun.
    if (frame_done) begin
      out_d = {serialInput, shreg[WIDTH-1:1]};
      dv_d  = 1'b1;
      if (dv_q && !readAck) begin
        ovr_d = 1'b1;
      end
    end else if (dv_q && readAck) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clockpulse or negedge notclear) begin
    if (!notclear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign notout    = ~out_q;
  assign dataValid = dv_q;
  assign busy      = in_shift;
  assign overrun   = ovr_q;

endmodule
